fsk2_modulator: RTL and testbench
=================================

Name: fsk2_modulator

Overview:
- Binary FSK transmitter for the FSK2 link; the transmit counterpart of the receive chain (mixer, FIR low-pass, slicer).
- Accepts bytes over a valid/ready handshake and frames them UART-style: start 0, 8 data bits LSB first, stop 1.
- Each bit is keyed onto a phase-continuous DDS carrier: F0 tone for 0, F1 tone for 1.
- Produces a 16-bit signed sample every clock for the DAC path.

Parameters:
- BAUD_DIV, 1000: clocks per bit; legal range is 2 or more.
- F0_WORD, 32'd85899346: phase increment for bit 0 (1 MHz at 50 MHz).
- F1_WORD, 32'd171798692: phase increment for bit 1 (2 MHz at 50 MHz).

Ports:
- sys_clk, input, 1: single clock; all logic on the rising edge.
- sys_rst_n, input, 1: asynchronous, active-high reset. High means reset, despite the name.
- tx_data, input, 8: byte to send.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: block accepts tx_data this cycle.
- tx_busy, output, 1: a frame is in progress.
- bit_out, output, 1: bit currently being keyed (mark = 1).
- sym_strobe, output, 1: one-cycle pulse on the first clock of each bit.
- y, output, 16: signed sine sample.

Behaviour:
- Reset values:
  - state IDLE, tx_ready 1, tx_busy 0, bit_out 1, sym_strobe 0, y 0.
  - Phase accumulator 0, baud counter 0, bit index 0.
- Handshake:
  - A byte is accepted on a cycle where tx_valid and tx_ready are both high; tx_data is latched into a shift register on that cycle.
  - tx_ready is high in IDLE, and also on the last clock of STOP (baud counter = BAUD_DIV-1). It is low at all other times.
  - tx_data is ignored when tx_ready is low.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: bit_out = 1, so the mark tone is sent continuously. On accept, go to START next cycle.
  - START: bit_out = 0 for BAUD_DIV clocks, then go to DATA.
  - DATA: bit_out = shift register LSB. Shift right every BAUD_DIV clocks. After 8 bits, go to STOP.
  - STOP: bit_out = 1 for BAUD_DIV clocks.
  - End of STOP with an accept on its last clock: go straight to START, with no idle gap. Otherwise go to IDLE.
- Counters and status:
  - Baud counter counts 0..BAUD_DIV-1 and clears on every bit boundary and on entry to START.
  - sym_strobe pulses when the counter is 0 in START, DATA or STOP.
  - tx_busy = state != IDLE.
- DDS:
  - Each cycle: phase_acc <= phase_acc + (bit_out ? F1_WORD : F0_WORD), wrapping mod 2^32.
  - phase_acc is never cleared except by reset. Tone switches are therefore phase-continuous, with no jump in the accumulator.
  - LUT address = phase_acc[31:24].
  - LUT[k] = round(32767*sin(2*pi*k/256)). Full table or quarter-wave symmetry is allowed; either must give identical values.
  - y is the registered LUT output.
- Latency:
  - A bit_out change at cycle t changes the increment applied at the edge ending cycle t.
  - y reflects the new slope from cycle t+2.
- Frame length: 10*BAUD_DIV clocks, from the first START clock to the last STOP clock.
- Reset mid-frame: the frame is aborted immediately (asynchronous), all registers return to reset values, and no partial byte resumes.
- tx_valid high during reset is ignored; the first accept can occur on the first clock after reset deasserts.

Optional Feature:
- Macro: FSK2_PARITY_EN.
- Defined:
  - An extra PARITY state sits between DATA and STOP.
  - bit_out = even parity, i.e. the XOR of the 8 data bits, for BAUD_DIV clocks.
  - Frame becomes 11*BAUD_DIV clocks.
- Undefined: no PARITY state; 10-bit frame.

Test Plan:
- Reset: assert sys_rst_n high mid-run, then release -> y=0, tx_ready=1, tx_busy=0, bit_out=1 on the first post-reset cycle.
- Idle tone: F1_WORD=32'h10000000, no tx_valid -> y repeats every 16 clocks; sample sequence matches LUT[0,16,32,...], with LUT[64]=32767.
- Single byte: BAUD_DIV=4, send 8'hA5 -> bit_out = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; tx_busy high 40 clocks; 10 sym_strobe pulses.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF -> second accept on the last STOP clock of the first frame; START follows with zero IDLE cycles; phase_acc steps by exactly F0/F1 every cycle, with no jumps.
- Abort: reset pulsed at bit 4 of 8'h3C -> outputs return to reset values at once; a following 8'h55 sends a clean full frame.
- Parity (FSK2_PARITY_EN defined): BAUD_DIV=2, send 8'h07 -> parity bit 1 appears before stop; frame is 22 clocks.

Source files
------------

// File: rtl/fsk2_modulator.sv
// Binary FSK transmitter: UART-framed bytes keyed onto a phase-continuous DDS sine.
// Optional even-parity bit between data and stop when FSK2_PARITY_EN is defined.
module fsk2_modulator #(
  parameter int unsigned BAUD_DIV = 1000,
  parameter logic [31:0] F0_WORD  = 32'd85899346,
  parameter logic [31:0] F1_WORD  = 32'd171798692
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_busy,
  output logic               bit_out,
  output logic               sym_strobe,
  output logic signed [15:0] y
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64
  localparam logic [14:0] QSIN [0:64] = '{
    15'd0,     15'd804,   15'd1608,  15'd2410,  15'd3212,  15'd4011,  15'd4808,  15'd5602,
    15'd6393,  15'd7179,  15'd7962,  15'd8739,  15'd9512,  15'd10278, 15'd11039, 15'd11793,
    15'd12539, 15'd13279, 15'd14010, 15'd14732, 15'd15446, 15'd16151, 15'd16846, 15'd17530,
    15'd18204, 15'd18868, 15'd19519, 15'd20159, 15'd20787, 15'd21403, 15'd22005, 15'd22594,
    15'd23170, 15'd23731, 15'd24279, 15'd24811, 15'd25329, 15'd25832, 15'd26319, 15'd26790,
    15'd27245, 15'd27683, 15'd28105, 15'd28510, 15'd28898, 15'd29268, 15'd29621, 15'd29956,
    15'd30273, 15'd30571, 15'd30852, 15'd31113, 15'd31356, 15'd31580, 15'd31785, 15'd31971,
    15'd32137, 15'd32285, 15'd32412, 15'd32521, 15'd32609, 15'd32678, 15'd32728, 15'd32757,
    15'd32767
  };

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [31:0]   phase_q, phase_d;
  logic [15:0]   y_q, y_d;
  logic          bit_end;
  logic          accept;
  logic [5:0]    lut_idx;
  logic [6:0]    lut_k;
  logic [15:0]   lut_mag;
`ifdef FSK2_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);
  assign accept  = tx_valid & tx_ready;
  assign y       = y_q;

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
`ifdef FSK2_PARITY_EN
      S_DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
`else
      S_DATA:   if (bit_end && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
      // A byte accepted on the last stop clock chains straight into the next start bit
      S_STOP:   if (bit_end) state_d = accept ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready   = (state_q == S_IDLE) || (state_q == S_STOP && bit_end);
    tx_busy    = (state_q != S_IDLE);
    sym_strobe = (state_q != S_IDLE) && (baud_q == '0);
    case (state_q)
      S_START:  bit_out = 1'b0;
      S_DATA:   bit_out = shift_q[0];
`ifdef FSK2_PARITY_EN
      S_PARITY: bit_out = parity_q;
`endif
      default:  bit_out = 1'b1;
    endcase
  end

  always_comb begin
    baud_d    = (state_q == S_IDLE || bit_end) ? '0 : baud_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (accept) begin
      bit_idx_d = 3'd0;
      shift_d   = tx_data;
    end else if (state_q == S_DATA && bit_end) begin
      bit_idx_d = bit_idx_q + 3'd1;
      shift_d   = {1'b0, shift_q[7:1]};
    end
    phase_d = phase_q + (bit_out ? F1_WORD : F0_WORD);
  end

`ifdef FSK2_PARITY_EN
  // Data bits are shifted out, so parity is captured from the byte at accept time
  assign parity_d = accept ? ^tx_data : parity_q;
`endif

  always_comb begin
    lut_idx = phase_q[29:24];
    lut_k   = phase_q[30] ? (7'd64 - {1'b0, lut_idx}) : {1'b0, lut_idx};
    lut_mag = {1'b0, QSIN[lut_k]};
    y_d     = phase_q[31] ? (16'd0 - lut_mag) : lut_mag;
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      phase_q   <= 32'd0;
      y_q       <= 16'd0;
`ifdef FSK2_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      phase_q   <= phase_d;
      y_q       <= y_d;
`ifdef FSK2_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fsk2_modulator.sv
// Table-driven bench for fsk2_modulator; expected y comes from a $sin reference and a phase model.
module tb_fsk2_modulator;
`ifdef FSK2_PARITY_EN
  localparam int BD = 2;
  localparam int NB = 11;
`else
  localparam int BD = 4;
  localparam int NB = 10;
`endif
  localparam logic [31:0] F0 = 32'h03000000;
  localparam logic [31:0] F1 = 32'h10000000;

  typedef logic [0:NB-1] frame_t;
  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic       bitv;
    logic       strobe;
  } vec_t;

`ifdef FSK2_PARITY_EN
  localparam frame_t FR_A5 = 11'b01010010101;
  localparam frame_t FR_00 = 11'b00000000001;
  localparam frame_t FR_FF = 11'b01111111101;
  localparam frame_t FR_3C = 11'b00011110001;
  localparam frame_t FR_55 = 11'b01010101001;
  localparam frame_t FR_07 = 11'b01110000011;
`else
  localparam frame_t FR_A5 = 10'b0101001011;
  localparam frame_t FR_00 = 10'b0000000001;
  localparam frame_t FR_FF = 10'b0111111111;
  localparam frame_t FR_3C = 10'b0001111001;
  localparam frame_t FR_55 = 10'b0101010101;
`endif

  logic               sys_clk;
  logic               sys_rst_n;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               tx_busy;
  logic               bit_out;
  logic               sym_strobe;
  logic signed [15:0] y;

  fsk2_modulator #(
    .BAUD_DIV (BD),
    .F0_WORD  (F0),
    .F1_WORD  (F1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .bit_out    (bit_out),
    .sym_strobe (sym_strobe),
    .y          (y)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          strobe_cnt;
  int          busy_cnt;
  logic [31:0] ph_last;
  logic [31:0] ph_cur;

  function automatic int lut_ref(input logic [7:0] k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add_idle(input int n, input logic v, input logic [7:0] d);
    for (int i = 0; i < n; i++) vecs.push_back('{v, d, 1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic add_frame(input frame_t f, input logic v, input logic [7:0] d);
    for (int k = 0; k < NB * BD; k++)
      vecs.push_back('{v, d, (k == NB * BD - 1), 1'b1, f[k / BD], (k % BD == 0)});
  endtask

  // Checks outputs of the current cycle, advances the phase model, drives the record's inputs
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check($sformatf("tx_ready[%0d]", i), int'(tx_ready), int'(vecs[i].ready));
      check($sformatf("tx_busy[%0d]", i), int'(tx_busy), int'(vecs[i].busy));
      check($sformatf("bit_out[%0d]", i), int'(bit_out), int'(vecs[i].bitv));
      check($sformatf("sym_strobe[%0d]", i), int'(sym_strobe), int'(vecs[i].strobe));
      check($sformatf("y[%0d]", i), int'(y), lut_ref(ph_last[31:24]));
      strobe_cnt += int'(sym_strobe);
      busy_cnt   += int'(tx_busy);
      ph_last = ph_cur;
      ph_cur  = ph_cur + (vecs[i].bitv ? F1 : F0);
      tx_valid = vecs[i].valid;
      tx_data  = vecs[i].data;
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(tx_ready), 1);
    check({tag, "_busy"}, int'(tx_busy), 0);
    check({tag, "_bit"}, int'(bit_out), 1);
    check({tag, "_strobe"}, int'(sym_strobe), 0);
    check({tag, "_y"}, int'(y), 0);
  endtask

  int a5_lo, a5_hi, main_hi, ab_lo, cl_lo;

  initial begin
    sys_rst_n  = 1'b1;
    tx_valid   = 1'b1;
    tx_data    = 8'hC3;
    strobe_cnt = 0;
    busy_cnt   = 0;
    ph_last    = 32'd0;
    ph_cur     = 32'd0;

    add_idle(20, 1'b0, 8'h00);
    add_idle(1, 1'b1, 8'hA5);
    a5_lo = vecs.size();
    add_frame(FR_A5, 1'b0, 8'h00);
    a5_hi = vecs.size() - 1;
    add_idle(3, 1'b0, 8'h00);
    add_idle(1, 1'b1, 8'h00);
    add_frame(FR_00, 1'b1, 8'hFF);
    add_frame(FR_FF, 1'b0, 8'h00);
    add_idle(3, 1'b0, 8'h00);
`ifdef FSK2_PARITY_EN
    add_idle(1, 1'b1, 8'h07);
    add_frame(FR_07, 1'b0, 8'h00);
    add_idle(2, 1'b0, 8'h00);
`endif
    main_hi = vecs.size() - 1;
    ab_lo = vecs.size();
    add_idle(1, 1'b1, 8'h3C);
    add_frame(FR_3C, 1'b0, 8'h00);
    cl_lo = vecs.size();
    add_idle(1, 1'b1, 8'h55);
    add_frame(FR_55, 1'b0, 8'h00);
    add_idle(3, 1'b0, 8'h00);

    // Reset held with tx_valid high; the accept must not survive it
    repeat (3) @(negedge sys_clk);
    #1;
    check_reset_outputs("rst_hold");
    sys_rst_n = 1'b0;
    tx_valid  = 1'b0;

    run_vecs(0, a5_lo - 1);
    strobe_cnt = 0;
    busy_cnt   = 0;
    run_vecs(a5_lo, a5_hi);
    check("a5_strobes", strobe_cnt, NB);
    check("a5_busy_clocks", busy_cnt, NB * BD);
    run_vecs(a5_hi + 1, main_hi);

    // Abort in the middle of data bit 4 of 8'h3C
    run_vecs(ab_lo, ab_lo + 1 + 5 * BD);
    check("abort_pre_busy", int'(tx_busy), 1);
    check("abort_pre_bit", int'(bit_out), 1);
    sys_rst_n = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge sys_clk);
    #1;
    check_reset_outputs("abort_held");
    sys_rst_n = 1'b0;
    ph_last   = 32'd0;
    ph_cur    = 32'd0;
    run_vecs(cl_lo, vecs.size() - 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
